// File: rtl/fifo_rd_streamer.sv
//------------------------------------------------------------------------------
// Module      : fifo_rd_streamer
// Description : Read-side companion for the narrowing FIFO. Issues rden_o to the
//               FIFO, captures rdata_i one cycle later into a 2-entry circular
//               buffer, and presents the words downstream as a valid/ready
//               stream at up to one beat per cycle.
//               Optional packet tagging is enabled by defining the macro
//               FIFO_RD_STREAMER_LAST_EN. With it, out_last_o marks every
//               BEATS_PER_PKT-th beat. Without it, out_last_o is tied to 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_rd_streamer #(
    parameter int DATA_WIDTH    = 16,
    parameter int BEATS_PER_PKT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rden_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rdempty_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o
);

    // Only 1, 2 and 4 beats per packet are meaningful for the FIFO width ratios.
    if (!(BEATS_PER_PKT == 1 || BEATS_PER_PKT == 2 || BEATS_PER_PKT == 4)) begin : g_bad_bpp
        $error("fifo_rd_streamer: BEATS_PER_PKT must be 1, 2 or 4");
    end

    logic [DATA_WIDTH-1:0] r_buf [0:1];
    logic                  r_wptr;
    logic                  r_rptr;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic                  w_pop;
    logic [2:0]            w_credit;

    // A beat leaves whenever the head entry is offered and accepted.
    assign w_pop = out_valid_o & out_ready_i;

    // Entries committed after this cycle: occupied plus landing minus leaving.
    // This is also the next occupancy, so one adder serves both purposes.
    assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Read only when a slot is guaranteed for the returning word.
    assign rden_o = ~rst & ~rdempty_i & (w_credit < 3'd2);

    // Outputs come straight from state registers; rdata_i never reaches them
    // combinationally.
    assign out_valid_o = (r_occ != 2'd0);
    assign out_data_o  = r_buf[r_rptr];

    // Track the in-flight read and advance pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_inflight <= rden_o;
            if (r_inflight) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= w_credit[1:0];
        end
    end

    // Land the FIFO word one cycle after its read strobe. A read issued just
    // before reset is dropped here, so it never becomes visible.
    always_ff @(posedge clk) begin
        if (!rst && r_inflight) begin
            r_buf[r_wptr] <= rdata_i;
        end
    end

`ifdef FIFO_RD_STREAMER_LAST_EN
    localparam int c_BEAT_W = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BEATS_PER_PKT - 1);

    logic [c_BEAT_W-1:0] r_beat;

    // Count accepted beats within a packet; alignment restarts after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_pop) begin
            if (r_beat == c_LAST_BEAT) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + c_BEAT_W'(1);
            end
        end
    end

    assign out_last_o = out_valid_o & (r_beat == c_LAST_BEAT);
`else
    assign out_last_o = 1'b0;
`endif

endmodule

`default_nettype wire
